// File: rtl/updown_counter.sv
// updown_counter: parametrised up/down counter with load, direction control,
// wrap / saturate / one-shot terminal modes and a registered terminal flag.
// Optional input prescaler compiled in with `define UPDOWN_COUNTER_PRESCALE_EN.
module updown_counter #(
   parameter int WIDTH   = 16,
   parameter int PRESC_W = 4
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               en,
   input  logic               up,
   input  logic [1:0]         mode,
   input  logic               load,
   input  logic [WIDTH-1:0]   load_val,
`ifdef UPDOWN_COUNTER_PRESCALE_EN
   input  logic [PRESC_W-1:0] presc_div,
`endif
   output logic [WIDTH-1:0]   count,
   output logic               done,
   output logic               running
);

   localparam logic [1:0] MODE_WRAP    = 2'd0;
   localparam logic [1:0] MODE_SAT     = 2'd1;
   localparam logic [1:0] MODE_ONESHOT = 2'd2;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_HALT = 2'd2
   } os_state_t;

   os_state_t        state, state_nxt;
   logic [WIDTH-1:0] cnt_nxt;
   logic             done_nxt;
   logic [WIDTH-1:0] term;
   logic [WIDTH-1:0] stepped;
   logic             at_term;
   logic             oneshot;
   logic             tick;
   logic             step;

`ifdef UPDOWN_COUNTER_PRESCALE_EN
   logic [PRESC_W-1:0] presc, presc_nxt;

   // A tick fires on the enabled cycle where the prescaler matches the divisor
   assign tick = (presc == presc_div);

   // Prescaler advances only on enabled cycles; load restarts the divide period
   always_comb begin
      presc_nxt = presc;
      if (load)
         presc_nxt = '0;
      else if (en)
         presc_nxt = tick ? '0 : presc + 1'b1;
   end

   // Prescaler register
   always_ff @(posedge clk) begin
      if (reset) presc <= '0;
      else       presc <= presc_nxt;
   end
`else
   assign tick = 1'b1;
`endif

   assign term    = up ? '1 : '0;
   assign at_term = (count == term);
   assign stepped = up ? count + 1'b1 : count - 1'b1;
   assign oneshot = (mode == MODE_ONESHOT);
   // One-shot only counts while armed; other modes count whenever enabled
   assign step    = en & tick & (~oneshot | (state == S_RUN));
   assign running = (state == S_RUN);

   // Next count / flag / one-shot state; load wins over any step
   always_comb begin
      cnt_nxt   = count;
      done_nxt  = 1'b0;
      state_nxt = S_IDLE;
      if (load) begin
         cnt_nxt   = load_val;
         state_nxt = oneshot ? S_RUN : S_IDLE;
      end else begin
         case (mode)
            MODE_SAT: begin
               // compare before update so a step at the terminal holds
               if (step && !at_term) cnt_nxt = stepped;
               done_nxt = (cnt_nxt == term);
            end
            MODE_ONESHOT: begin
               case (state)
                  S_RUN: begin
                     state_nxt = S_RUN;
                     if (step) begin
                        // a run loaded at the terminal halts without moving
                        if (!at_term) cnt_nxt = stepped;
                        if (cnt_nxt == term) begin
                           state_nxt = S_HALT;
                           done_nxt  = 1'b1;
                        end
                     end
                  end
                  S_HALT: begin
                     state_nxt = S_HALT;
                     done_nxt  = 1'b1;
                  end
                  default: state_nxt = S_IDLE;
               endcase
            end
            default: begin
               // wrap (and reserved): one-cycle pulse when a step lands on T
               if (step) begin
                  cnt_nxt  = stepped;
                  done_nxt = (stepped == term);
               end
            end
         endcase
      end
   end

   // Count, flag and one-shot state registers
   always_ff @(posedge clk) begin
      if (reset) begin
         count <= '0;
         done  <= 1'b0;
         state <= S_IDLE;
      end else begin
         count <= cnt_nxt;
         done  <= done_nxt;
         state <= state_nxt;
      end
   end

endmodule
